// File: rtl/branch_resolve_bht.sv
// ---------------------------------------------------------------------------
// branch_resolve_bht
//
// Branch history table of 2-bit saturating counters combined with a RISC-V
// branch-condition resolver.
//
// The lookup path indexes the table with the fetch PC and returns the
// counter's MSB as a registered prediction. The resolve path evaluates the
// branch condition from funct3 and the two operands, then does three things:
// it registers the actual outcome, flags a mispredict against the prediction
// that was used, and trains the counter at the resolving PC. A saturating
// statistics counter tracks mispredicts.
//
// Handshake: neither path has backpressure. pred_valid and res_valid are
// single-cycle request strobes that are accepted on every rising edge. Each
// response appears exactly one cycle later. pred_out_valid qualifies
// pred_taken. res_taken, mispredict and illegal_fun3 are per-cycle pulses
// that are 0 in any cycle that does not follow a resolve.
//
// Ports
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   pred_valid     : lookup request
//   pred_pc        : PC of the fetched instruction
//   pred_taken     : registered prediction (counter MSB)
//   pred_out_valid : pred_taken is valid this cycle
//   res_valid      : a branch resolves this cycle
//   res_pc         : PC of the resolving branch
//   res_fun3       : RISC-V branch funct3
//   res_rs1/rs2    : branch operands
//   res_pred_taken : prediction that was used for the resolving branch
//   res_taken      : registered actual outcome
//   mispredict     : one-cycle pulse when the outcome differs from the prediction
//   illegal_fun3   : one-cycle pulse for funct3 010 / 011
//   mispredict_cnt : saturating mispredict count
//   stat_clr       : synchronous clear of mispredict_cnt (wins over increment)
// ---------------------------------------------------------------------------
module branch_resolve_bht #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int BHT_DEPTH  = 64,
    parameter int STAT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pred_valid,
    input  logic [PC_WIDTH-1:0]   pred_pc,
    output logic                  pred_taken,
    output logic                  pred_out_valid,
    input  logic                  res_valid,
    input  logic [PC_WIDTH-1:0]   res_pc,
    input  logic [2:0]            res_fun3,
    input  logic [DATA_WIDTH-1:0] res_rs1,
    input  logic [DATA_WIDTH-1:0] res_rs2,
    input  logic                  res_pred_taken,
    output logic                  res_taken,
    output logic                  mispredict,
    output logic                  illegal_fun3,
    output logic [STAT_WIDTH-1:0] mispredict_cnt,
    input  logic                  stat_clr
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // 2-bit counter encodings
    localparam logic [1:0] CTR_SNT   = 2'b00;
    localparam logic [1:0] CTR_WNT   = 2'b01;
    localparam logic [1:0] CTR_ST    = 2'b11;

    localparam logic [STAT_WIDTH-1:0] CNT_MAX = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            bht_q [BHT_DEPTH];
    logic                  pred_taken_q,     pred_taken_d;
    logic                  pred_out_valid_q, pred_out_valid_d;
    logic                  res_taken_q,      res_taken_d;
    logic                  mispredict_q,     mispredict_d;
    logic                  illegal_fun3_q,   illegal_fun3_d;
    logic [STAT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

    // ------------------------------------------------------------------
    // Index extraction: the word-aligned PC bits above the byte offset.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;

    assign pred_idx = pred_pc[IDX_W+1:2];
    assign res_idx  = res_pc[IDX_W+1:2];

    // Only the index bits of the PCs are used. The rest is folded here so
    // that the unused bits are visible and intentional.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc, res_pc};

    // ------------------------------------------------------------------
    // Branch condition
    // ------------------------------------------------------------------
    logic cond_taken;
    logic fun3_legal;

    always_comb begin
        cond_taken = 1'b0;
        fun3_legal = 1'b1;
        case (res_fun3)
            3'b000:  cond_taken = (res_rs1 == res_rs2);
            3'b001:  cond_taken = (res_rs1 != res_rs2);
            3'b100:  cond_taken = ($signed(res_rs1) <  $signed(res_rs2));
            3'b101:  cond_taken = ($signed(res_rs1) >= $signed(res_rs2));
            3'b110:  cond_taken = (res_rs1 <  res_rs2);
            3'b111:  cond_taken = (res_rs1 >= res_rs2);
            default: fun3_legal = 1'b0;  // 010 / 011 are not branches
        endcase
    end

    // A resolve only counts when funct3 is a real branch. Illegal encodings
    // must neither report an outcome nor train the table.
    logic res_accept;
    assign res_accept = res_valid & fun3_legal;

    // ------------------------------------------------------------------
    // Counter training
    // ------------------------------------------------------------------
    logic [1:0] upd_ctr_cur;
    logic [1:0] upd_ctr_d;

    assign upd_ctr_cur = bht_q[res_idx];

    always_comb begin
        upd_ctr_d = upd_ctr_cur;
        if (cond_taken) begin
            if (upd_ctr_cur != CTR_ST) begin
                upd_ctr_d = upd_ctr_cur + 2'd1;
            end
        end else begin
            if (upd_ctr_cur != CTR_SNT) begin
                upd_ctr_d = upd_ctr_cur - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state for registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        // The table read samples bht_q before the edge. A same-cycle
        // update to the same entry is therefore not visible to this lookup.
        pred_out_valid_d = pred_valid;
        pred_taken_d     = pred_valid & bht_q[pred_idx][1];

        res_taken_d      = res_accept & cond_taken;
        mispredict_d     = res_accept & (cond_taken ^ res_pred_taken);
        illegal_fun3_d   = res_valid & ~fun3_legal;

        mispredict_cnt_d = mispredict_cnt_q;
        if (stat_clr) begin
            mispredict_cnt_d = '0;
        end else if (mispredict_d && (mispredict_cnt_q != CNT_MAX)) begin
            mispredict_cnt_d = mispredict_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= CTR_WNT;
            end
        end else if (res_accept) begin
            bht_q[res_idx] <= upd_ctr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_taken_q     <= 1'b0;
            pred_out_valid_q <= 1'b0;
            res_taken_q      <= 1'b0;
            mispredict_q     <= 1'b0;
            illegal_fun3_q   <= 1'b0;
            mispredict_cnt_q <= '0;
        end else begin
            pred_taken_q     <= pred_taken_d;
            pred_out_valid_q <= pred_out_valid_d;
            res_taken_q      <= res_taken_d;
            mispredict_q     <= mispredict_d;
            illegal_fun3_q   <= illegal_fun3_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign pred_taken     = pred_taken_q;
    assign pred_out_valid = pred_out_valid_q;
    assign res_taken      = res_taken_q;
    assign mispredict     = mispredict_q;
    assign illegal_fun3   = illegal_fun3_q;
    assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_bht
//
// Directed bench for branch_resolve_bht with STAT_WIDTH=4 so that counter
// saturation is reachable. The driver issues one cycle of stimulus per call
// and queues the hand-computed response for the cycle after it. A monitor
// on the falling edge pops each entry when it falls due and compares every
// output.
// ---------------------------------------------------------------------------
module tb_branch_resolve_bht;

    localparam int DW = 32;
    localparam int PW = 32;
    localparam int SW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals ----------------
    logic          pred_valid;
    logic [PW-1:0] pred_pc;
    logic          pred_taken;
    logic          pred_out_valid;
    logic          res_valid;
    logic [PW-1:0] res_pc;
    logic [2:0]    res_fun3;
    logic [DW-1:0] res_rs1;
    logic [DW-1:0] res_rs2;
    logic          res_pred_taken;
    logic          res_taken;
    logic          mispredict;
    logic          illegal_fun3;
    logic [SW-1:0] mispredict_cnt;
    logic          stat_clr;

    branch_resolve_bht #(
        .DATA_WIDTH (DW),
        .PC_WIDTH   (PW),
        .BHT_DEPTH  (64),
        .STAT_WIDTH (SW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_out_valid (pred_out_valid),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_fun3       (res_fun3),
        .res_rs1        (res_rs1),
        .res_rs2        (res_rs2),
        .res_pred_taken (res_pred_taken),
        .res_taken      (res_taken),
        .mispredict     (mispredict),
        .illegal_fun3   (illegal_fun3),
        .mispredict_cnt (mispredict_cnt),
        .stat_clr       (stat_clr)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int unsigned   due;
        logic          pt;
        logic          pov;
        logic          rt;
        logic          mp;
        logic          ill;
        logic [SW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every output in the cycle an entry falls due.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            if (e.due != cyc) begin
                chk("stale_entry", cyc, e.due);
            end
            chk("pred_taken",     {31'b0, pred_taken},     {31'b0, e.pt});
            chk("pred_out_valid", {31'b0, pred_out_valid}, {31'b0, e.pov});
            chk("res_taken",      {31'b0, res_taken},      {31'b0, e.rt});
            chk("mispredict",     {31'b0, mispredict},     {31'b0, e.mp});
            chk("illegal_fun3",   {31'b0, illegal_fun3},   {31'b0, e.ill});
            chk("mispredict_cnt", {28'b0, mispredict_cnt}, {28'b0, e.cnt});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        pred_valid     = 1'b0;
        pred_pc        = '0;
        res_valid      = 1'b0;
        res_pc         = '0;
        res_fun3       = 3'b000;
        res_rs1        = '0;
        res_rs2        = '0;
        res_pred_taken = 1'b0;
        stat_clr       = 1'b0;
    endtask

    // Called just after a rising edge. Drives one cycle of stimulus and
    // queues the response expected after the next rising edge.
    task automatic issue(input logic pv, input logic [31:0] ppc,
                         input logic rv, input logic [31:0] rpc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic rpt,
                         input logic clr,
                         input logic e_pt, input logic e_pov, input logic e_rt,
                         input logic e_mp, input logic e_ill, input logic [SW-1:0] e_cnt);
        exp_t e;
        pred_valid     = pv;
        pred_pc        = ppc;
        res_valid      = rv;
        res_pc         = rpc;
        res_fun3       = f3;
        res_rs1        = a;
        res_rs2        = b;
        res_pred_taken = rpt;
        stat_clr       = clr;
        e.due = cyc + 1;
        e.pt  = e_pt;
        e.pov = e_pov;
        e.rt  = e_rt;
        e.mp  = e_mp;
        e.ill = e_ill;
        e.cnt = e_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic lookup(input logic [31:0] pc, input logic e_pt, input logic [SW-1:0] e_cnt);
        issue(1'b1, pc, 1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b0,
              e_pt, 1'b1, 1'b0, 1'b0, 1'b0, e_cnt);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b, input logic rpt,
                           input logic e_rt, input logic e_mp, input logic e_ill,
                           input logic [SW-1:0] e_cnt);
        issue(1'b0, 32'h0, 1'b1, pc, f3, a, b, rpt, 1'b0,
              1'b0, 1'b0, e_rt, e_mp, e_ill, e_cnt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pred_taken",     {31'b0, pred_taken},     32'h0);
        chk("rst_pred_out_valid", {31'b0, pred_out_valid}, 32'h0);
        chk("rst_res_taken",      {31'b0, res_taken},      32'h0);
        chk("rst_mispredict",     {31'b0, mispredict},     32'h0);
        chk("rst_illegal_fun3",   {31'b0, illegal_fun3},   32'h0);
        chk("rst_cnt",            {28'b0, mispredict_cnt}, 32'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fresh entry is weakly not-taken.
        lookup(32'h100, 1'b0, 4'd0);
        // Train idx 0 towards taken: 01->10->11->11, each a mispredict.
        resolve(32'h100, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
        resolve(32'h100, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
        resolve(32'h100, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
        lookup(32'h100, 1'b1, 4'd3);
        // 0x200 aliases to idx 0: PC bits above the index are ignored.
        lookup(32'h200, 1'b1, 4'd3);

        // Signed vs unsigned less-than on the same operands.
        resolve(32'h104, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
        resolve(32'h104, 3'b110, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd4);

        // Same-index lookup and taken update with entry at 01: old value read.
        issue(1'b1, 32'h108, 1'b1, 32'h108, 3'b001, 32'd1, 32'd2, 1'b0, 1'b0,
              1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd5);
        lookup(32'h108, 1'b1, 4'd5);

        // Illegal funct3: pulse, no outcome, no mispredict, no training.
        resolve(32'h108, 3'b010, 32'd5, 32'd6, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        resolve(32'h108, 3'b011, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
        lookup(32'h108, 1'b1, 4'd5);

        // Remaining conditions; idx 3 walks 01->00->01->00->00->01.
        resolve(32'h10C, 3'b101, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
        resolve(32'h10C, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd6);
        lookup(32'h10C, 1'b0, 4'd6);
        resolve(32'h10C, 3'b001, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6);
        resolve(32'h10C, 3'b001, 32'd7, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6);
        resolve(32'h10C, 3'b000, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6);
        lookup(32'h10C, 1'b0, 4'd6);

        // Full-width compare: operands differ only in the MSB.
        resolve(32'h110, 3'b000, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7);
        resolve(32'h110, 3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7);

        // 13 more mispredicts (20 total): counter sticks at 15.
        for (int i = 0; i < 13; i++) begin
            resolve(32'h114, 3'b000, 32'd9, 32'd9, 1'b0, 1'b1, 1'b1, 1'b0,
                    (8 + i > 15) ? 4'd15 : 4'(8 + i));
        end
        // Clear beats a same-cycle mispredict.
        issue(1'b0, 32'h0, 1'b1, 32'h114, 3'b000, 32'd9, 32'd9, 1'b0, 1'b1,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        resolve(32'h114, 3'b000, 32'd9, 32'd9, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1);

        // Idx 6 goes 01->10; outputs are non-zero going into the reset.
        resolve(32'h118, 3'b000, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
        @(negedge clk);
        #1;
        pred_valid     = 1'b1;
        pred_pc        = 32'h118;
        res_valid      = 1'b1;
        res_pc         = 32'h118;
        res_fun3       = 3'b000;
        res_rs1        = 32'd5;
        res_rs2        = 32'd5;
        res_pred_taken = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_pred_taken",     {31'b0, pred_taken},     32'h0);
        chk("midrst_pred_out_valid", {31'b0, pred_out_valid}, 32'h0);
        chk("midrst_res_taken",      {31'b0, res_taken},      32'h0);
        chk("midrst_mispredict",     {31'b0, mispredict},     32'h0);
        chk("midrst_illegal_fun3",   {31'b0, illegal_fun3},   32'h0);
        chk("midrst_cnt",            {28'b0, mispredict_cnt}, 32'h0);
        @(posedge clk);
        #1;
        idle_inputs();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Every entry is back at 01, including the one being trained.
        lookup(32'h118, 1'b0, 4'd0);
        lookup(32'h100, 1'b0, 4'd0);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_bht.md
BRANCH_RESOLVE_BHT -- requirements
Module: branch_resolve_bht

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the compared operands.
REQ-002 SHALL have parameter PC_WIDTH, default 32, meaning the width of the program counter.
REQ-003 SHALL have parameter BHT_DEPTH, default 64, meaning the number of BHT entries; it is a power of 2 and at least 4.
REQ-004 SHALL have parameter STAT_WIDTH, default 16, meaning the width of the mispredict counter.
REQ-005 SHALL have one clock and an asynchronous, active-low reset; all state is clocked on the rising edge.
REQ-006 SHALL have port clk, input, 1 bit: the system clock.
REQ-007 SHALL have port rst_n, input, 1 bit: the asynchronous active-low reset.
REQ-008 SHALL have port pred_valid, input, 1 bit: a lookup request.
REQ-009 SHALL have port pred_pc, input, PC_WIDTH bits: the PC of the fetched instruction.
REQ-010 SHALL have port pred_taken, output, 1 bit: the prediction, registered.
REQ-011 SHALL have port pred_out_valid, output, 1 bit: pred_taken is valid this cycle.
REQ-012 SHALL have port res_valid, input, 1 bit: a branch is resolving this cycle.
REQ-013 SHALL have port res_pc, input, PC_WIDTH bits: the PC of the resolving branch.
REQ-014 SHALL have port res_fun3, input, 3 bits: the RISC-V branch funct3.
REQ-015 SHALL have port res_rs1 and res_rs2, inputs, DATA_WIDTH bits each: the branch operands.
REQ-016 SHALL have port res_pred_taken, input, 1 bit: the prediction that was used for this branch.
REQ-017 SHALL have port res_taken, output, 1 bit: the actual outcome, registered.
REQ-018 SHALL have port mispredict, output, 1 bit: a one-cycle pulse when the outcome differs from the prediction.
REQ-019 SHALL have port illegal_fun3, output, 1 bit: a one-cycle pulse when funct3 is 010 or 011.
REQ-020 SHALL have port mispredict_cnt, output, STAT_WIDTH bits: the saturating mispredict count.
REQ-021 SHALL have port stat_clr, input, 1 bit: synchronously clears mispredict_cnt.

Function
REQ-022 SHALL compute the index as pc[log2(BHT_DEPTH)+1:2] for both the lookup and the update paths.
REQ-023 SHALL hold one 2-bit saturating counter per entry: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
REQ-024 SHALL, on pred_valid, register pred_taken as counter[idx][1] and assert pred_out_valid in the next cycle; both SHALL be 0 in the next cycle otherwise.
REQ-025 SHALL evaluate the condition combinationally from res_fun3 and the operands:
- 000: rs1==rs2
- 001: rs1!=rs2
- 100: rs1<rs2, signed
- 101: rs1>=rs2, signed
- 110: rs1<rs2, unsigned
- 111: rs1>=rs2, unsigned
- all comparisons use the full DATA_WIDTH.
REQ-026 SHALL, on res_valid with a legal funct3, register res_taken and register mispredict = taken XOR res_pred_taken; both are visible 1 cycle after res_valid.
REQ-027 SHALL, on res_valid with a legal funct3, update the counter at the resolve index at the same edge: increment, saturating at 11, if taken; decrement, saturating at 00, if not taken.
REQ-028 SHALL, on res_valid with funct3 010 or 011, pulse illegal_fun3, force res_taken=0 and mispredict=0, and leave the BHT unchanged.
REQ-029 SHALL, when res_valid is 0, drive res_taken, mispredict and illegal_fun3 to 0 in the next cycle.
REQ-030 SHALL, when a lookup and an update hit the same index in the same cycle, return the pre-update counter value (read-before-write).
REQ-031 SHALL increment mispredict_cnt by 1 for each mispredict and hold it at all-ones once it saturates, with no wrap.
REQ-032 SHALL give stat_clr priority over an increment in the same cycle; the counter reads 0 afterwards.
REQ-033 SHALL accept one lookup and one resolve per cycle, with no stalls and no backpressure.

Reset
REQ-034 SHALL, while rst_n=0, immediately force:
- all BHT entries to 01
- pred_taken, pred_out_valid, res_taken, mispredict, illegal_fun3 to 0
- mispredict_cnt to 0.
REQ-035 SHALL discard any lookup or resolve in flight when reset asserts mid-operation, with no partial BHT update.

Verification
REQ-036 Reset, then pred_valid with pred_pc=0x100 -> pred_taken=0, pred_out_valid=1 one cycle later.
REQ-037 Three resolves at pc 0x100, fun3=000, rs1=rs2=5, res_pred_taken=0 -> mispredict=1 each time, entry 01->10->11->11, mispredict_cnt=3, later lookup pred_taken=1.
REQ-038 fun3=100, rs1=0xFFFFFFFF, rs2=1 -> res_taken=1; fun3=110 with the same operands -> res_taken=0.
REQ-039 Lookup and resolve at the same index in the same cycle with the entry at 01 and outcome taken -> pred_taken=0; next lookup pred_taken=1.
REQ-040 fun3=011 with res_valid -> illegal_fun3 pulses, mispredict=0, BHT unchanged; STAT_WIDTH=4 with 20 mispredicts -> cnt=15; stat_clr together with a mispredict -> cnt=0.
REQ-041 Assert rst_n low during a resolve cycle -> all outputs 0 immediately, and the targeted entry reads 01 after release.
